lc3_mem_arbiter: RTL and testbench
==================================

Name: lc3_mem_arbiter

Overview:
Shares one single-ported, variable-latency memory between the LC3 instruction-fetch port (inst_mem interface) and the data-memory port. It accepts level-held read/write requests from both ports and grants one at a time. It drives the memory handshake and returns data with a one-cycle complete pulse to the granted port. Data accesses win by default, and a starvation counter guarantees fetch progress. It sits between the LC3 core and the memory model/agent in the bench top.

Parameters:
ADDR_W, 16, address width
DATA_W, 16, data width
MAX_DATA_STREAK, 4, consecutive data grants allowed while a fetch waits (1..15)
TIMEOUT, 64, cycles to wait for mem_ack before aborting an access (≥2)

Ports:
clock  in  1  system clock, all logic rising-edge
reset  in  1  synchronous, active-high reset
instrmem_rd  in  1  fetch request, held until complete_instr
pc  in  ADDR_W  fetch address
instr_dout  out  DATA_W  fetched instruction, valid with complete_instr
complete_instr  out  1  one-cycle fetch done pulse
data_rd  in  1  data read request (0 = write), sampled with data_req
data_req  in  1  data access request, held until complete_data
data_addr  in  ADDR_W  data address
data_din  in  DATA_W  write data
data_dout  out  DATA_W  read data, valid with complete_data
complete_data  out  1  one-cycle data done pulse
mem_req  out  1  memory access request, held until mem_ack
mem_we  out  1  1 = write
mem_addr  out  ADDR_W  memory address
mem_wdata  out  DATA_W  memory write data
mem_rdata  in  DATA_W  memory read data, valid with mem_ack
mem_ack  in  1  memory completes access this cycle
mem_err  out  1  one-cycle pulse on timeout abort

Behaviour:
- Clock is `clock`; reset is `reset`, synchronous and active-high. Reset overrides everything, including mid-access. After reset: state IDLE; mem_req, mem_we, complete_instr, complete_data, mem_err all 0; mem_addr, mem_wdata, instr_dout, data_dout all 0; streak and timeout counters 0.
- All outputs are registered.
- FSM states: IDLE, INST_BUSY, DATA_BUSY.
- IDLE, no request: remain in IDLE.
- IDLE, data_req=1 and (instrmem_rd=0 or streak<MAX_DATA_STREAK): go to DATA_BUSY. Latch data_addr/data_din/~data_rd into mem_addr/mem_wdata/mem_we. Assert mem_req next cycle.
- IDLE, instrmem_rd=1 and (data_req=0 or streak≥MAX_DATA_STREAK): go to INST_BUSY. Latch pc into mem_addr, mem_we=0, assert mem_req.
- Streak counter: increments on each data grant made while instrmem_rd=1. Clears on any instruction grant. Clears on any data grant made while instrmem_rd=0. Saturates at MAX_DATA_STREAK.
- BUSY states: hold mem_req and the latched address/data stable until a cycle where mem_ack=1. mem_ack may arrive in the first mem_req cycle. mem_ack while mem_req=0 is ignored.
- On mem_ack in INST_BUSY: next cycle instr_dout=mem_rdata and complete_instr=1 for exactly one cycle.
- On mem_ack in DATA_BUSY: next cycle complete_data=1 for one cycle. data_dout=mem_rdata for reads; data_dout is unchanged for writes.
- In the ack cycle, mem_req drops and the FSM returns to IDLE.
- Minimum latency: request sampled in IDLE at cycle N, mem_req high at N+1, ack at N+1, complete at N+2.
- The completion cycle is IDLE. Requests are re-sampled in it, and a still-held request is treated as new. Requesters must drop the request on seeing complete.
- Requests that change while their access is BUSY are ignored; the latched values are used.
- Timeout counter runs while BUSY. If it reaches TIMEOUT-1 without mem_ack:
  - drop mem_req and pulse mem_err;
  - pulse the owning port's complete with dout forced to 0 (LC3 NOP-safe);
  - return to IDLE.
- Only the granted port's complete fires. complete_instr and complete_data are never high together.

Decomposition:
- Shared package lc3_mem_arb_pkg holds:
  - enum arb_state_t {IDLE, INST_BUSY, DATA_BUSY};
  - ADDR_W/DATA_W default constants;
  - typedef mem_cmd_t struct {we, addr, wdata}.
- One natural sub-module, lc3_arb_streak_ctr: a saturating grant-streak counter producing force_inst.
- Timeout and FSM stay in the top.

Test Plan:
- Fetch only, pc=0x3000, mem_ack one cycle after mem_req with rdata=0x1220 -> mem_addr=0x3000, mem_we=0; complete_instr one cycle after ack; instr_dout=0x1220; total 3 cycles.
- Same-cycle requests, pc=0x3001 and data read addr=0x4000 -> data granted first (mem_addr=0x4000). After complete_data, fetch is granted.
- Fetch held while data_req issues back-to-back writes, MAX_DATA_STREAK=4 -> exactly 4 data grants, then instruction grant; streak returns to 0.
- Data write addr=0x5000, din=0xBEEF, ack in the first mem_req cycle -> mem_we=1, mem_wdata=0xBEEF; complete_data 2 cycles after request; data_dout unchanged.
- No mem_ack for TIMEOUT=64 cycles on fetch -> mem_err and complete_instr pulse together; instr_dout=0x0000; FSM in IDLE.
- Reset asserted in DATA_BUSY mid-wait -> next cycle all outputs 0; late mem_ack produces no complete.

Source files
------------

// File: rtl/lc3_mem_arb_pkg.sv
// Shared types and defaults for the LC3 fetch/data memory arbiter.
package lc3_mem_arb_pkg;

  localparam int ADDR_W_DEF = 16;
  localparam int DATA_W_DEF = 16;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    INST_BUSY = 2'd1,
    DATA_BUSY = 2'd2
  } arb_state_t;

  typedef struct packed {
    logic                  we;
    logic [ADDR_W_DEF-1:0] addr;
    logic [DATA_W_DEF-1:0] wdata;
  } mem_cmd_t;

endpackage

// File: rtl/lc3_mem_arbiter_if.sv
// Core-side request ports plus memory-side handshake for the LC3 memory arbiter.
interface lc3_mem_arbiter_if
  import lc3_mem_arb_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) ();
  // Handshake: instrmem_rd / data_req are level-held until their one-cycle
  // complete pulse and must drop on seeing it; mem_req with its command is
  // held stable until a cycle with mem_ack, and mem_ack without mem_req is ignored.
  logic              instrmem_rd;
  logic [ADDR_W-1:0] pc;
  logic [DATA_W-1:0] instr_dout;
  logic              complete_instr;

  logic              data_rd;
  logic              data_req;
  logic [ADDR_W-1:0] data_addr;
  logic [DATA_W-1:0] data_din;
  logic [DATA_W-1:0] data_dout;
  logic              complete_data;

  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ack;
  logic              mem_err;

  modport master (
    input  instrmem_rd, pc, data_rd, data_req, data_addr, data_din, mem_rdata, mem_ack,
    output instr_dout, complete_instr, data_dout, complete_data,
           mem_req, mem_we, mem_addr, mem_wdata, mem_err
  );

  modport slave (
    output instrmem_rd, pc, data_rd, data_req, data_addr, data_din, mem_rdata, mem_ack,
    input  instr_dout, complete_instr, data_dout, complete_data,
           mem_req, mem_we, mem_addr, mem_wdata, mem_err
  );
endinterface

// File: rtl/lc3_arb_streak_ctr.sv
// Counts consecutive data grants taken while a fetch waits; force_inst
// hands the next grant to the fetch port once the limit is reached.
module lc3_arb_streak_ctr
  import lc3_mem_arb_pkg::*;
#(
  parameter int MAX_DATA_STREAK = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       data_grant,
  input  logic       inst_grant,
  input  logic       inst_waiting,
  output logic       force_inst,
  output logic [3:0] streak
);
  logic [3:0] streak_q, streak_d;

  always_comb begin
    streak_d = streak_q;
    if (inst_grant) begin
      streak_d = 4'd0;
    end else if (data_grant) begin
      if (!inst_waiting) begin
        streak_d = 4'd0;
      end else if (streak_q < 4'(MAX_DATA_STREAK)) begin
        streak_d = streak_q + 4'd1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) streak_q <= 4'd0;
    else       streak_q <= streak_d;
  end

  assign force_inst = (streak_q >= 4'(MAX_DATA_STREAK));
  assign streak     = streak_q;
endmodule

// File: rtl/lc3_mem_arbiter.sv
// Grants one shared variable-latency memory to the LC3 fetch or data port,
// data first, with a fetch-starvation limit and an access timeout.
module lc3_mem_arbiter
  import lc3_mem_arb_pkg::*;
#(
  parameter int ADDR_W          = ADDR_W_DEF,
  parameter int DATA_W          = DATA_W_DEF,
  parameter int MAX_DATA_STREAK = 4,
  parameter int TIMEOUT         = 64
) (
  input  logic               clock,
  input  logic               reset,
  lc3_mem_arbiter_if.master  bus,
  output arb_state_t         dbg_state,
  output logic [3:0]         dbg_streak
);
  localparam int TO_W = $clog2(TIMEOUT);

  arb_state_t        state_q, state_d;
  logic [TO_W-1:0]   to_q, to_d;
  logic              mem_req_q, mem_req_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [DATA_W-1:0] instr_dout_q, instr_dout_d;
  logic [DATA_W-1:0] data_dout_q, data_dout_d;
  logic              complete_instr_q, complete_instr_d;
  logic              complete_data_q, complete_data_d;
  logic              mem_err_q, mem_err_d;
  logic              force_inst, data_grant, inst_grant;

  assign data_grant = (state_q == IDLE) && bus.data_req && (!bus.instrmem_rd || !force_inst);
  assign inst_grant = (state_q == IDLE) && bus.instrmem_rd && (!bus.data_req || force_inst);

  lc3_arb_streak_ctr #(.MAX_DATA_STREAK(MAX_DATA_STREAK)) u_streak (
    .clock        (clock),
    .reset        (reset),
    .data_grant   (data_grant),
    .inst_grant   (inst_grant),
    .inst_waiting (bus.instrmem_rd),
    .force_inst   (force_inst),
    .streak       (dbg_streak)
  );

  always_comb begin
    state_d          = state_q;
    to_d             = to_q;
    mem_req_d        = mem_req_q;
    mem_we_d         = mem_we_q;
    mem_addr_d       = mem_addr_q;
    mem_wdata_d      = mem_wdata_q;
    instr_dout_d     = instr_dout_q;
    data_dout_d      = data_dout_q;
    complete_instr_d = 1'b0;
    complete_data_d  = 1'b0;
    mem_err_d        = 1'b0;
    unique case (state_q)
      IDLE: begin
        to_d = '0;
        if (data_grant) begin
          state_d     = DATA_BUSY;
          mem_req_d   = 1'b1;
          mem_we_d    = ~bus.data_rd;
          mem_addr_d  = bus.data_addr;
          mem_wdata_d = bus.data_din;
        end else if (inst_grant) begin
          state_d    = INST_BUSY;
          mem_req_d  = 1'b1;
          mem_we_d   = 1'b0;
          mem_addr_d = bus.pc;
        end
      end
      INST_BUSY, DATA_BUSY: begin
        if (bus.mem_ack) begin
          state_d   = IDLE;
          mem_req_d = 1'b0;
          to_d      = '0;
          if (state_q == INST_BUSY) begin
            complete_instr_d = 1'b1;
            instr_dout_d     = bus.mem_rdata;
          end else begin
            complete_data_d = 1'b1;
            if (!mem_we_q) data_dout_d = bus.mem_rdata;
          end
        end else if (to_q == TO_W'(TIMEOUT - 1)) begin
          // Abort returns zero so a starved fetch decodes as a harmless NOP.
          state_d   = IDLE;
          mem_req_d = 1'b0;
          mem_err_d = 1'b1;
          to_d      = '0;
          if (state_q == INST_BUSY) begin
            complete_instr_d = 1'b1;
            instr_dout_d     = '0;
          end else begin
            complete_data_d = 1'b1;
            data_dout_d     = '0;
          end
        end else begin
          to_d = to_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q          <= IDLE;
      to_q             <= '0;
      mem_req_q        <= 1'b0;
      mem_we_q         <= 1'b0;
      mem_addr_q       <= '0;
      mem_wdata_q      <= '0;
      instr_dout_q     <= '0;
      data_dout_q      <= '0;
      complete_instr_q <= 1'b0;
      complete_data_q  <= 1'b0;
      mem_err_q        <= 1'b0;
    end else begin
      state_q          <= state_d;
      to_q             <= to_d;
      mem_req_q        <= mem_req_d;
      mem_we_q         <= mem_we_d;
      mem_addr_q       <= mem_addr_d;
      mem_wdata_q      <= mem_wdata_d;
      instr_dout_q     <= instr_dout_d;
      data_dout_q      <= data_dout_d;
      complete_instr_q <= complete_instr_d;
      complete_data_q  <= complete_data_d;
      mem_err_q        <= mem_err_d;
    end
  end

  assign bus.mem_req        = mem_req_q;
  assign bus.mem_we         = mem_we_q;
  assign bus.mem_addr       = mem_addr_q;
  assign bus.mem_wdata      = mem_wdata_q;
  assign bus.instr_dout     = instr_dout_q;
  assign bus.data_dout      = data_dout_q;
  assign bus.complete_instr = complete_instr_q;
  assign bus.complete_data  = complete_data_q;
  assign bus.mem_err        = mem_err_q;
  assign dbg_state          = state_q;
endmodule

// File: tb/tb_lc3_mem_arbiter.sv
// Bench for lc3_mem_arbiter: directed scenarios then random two-port traffic,
// against a memory agent and a scoreboard fed by a simple memory reference.
module tb_lc3_mem_arbiter;
  import lc3_mem_arb_pkg::*;

  localparam int AW   = 16;
  localparam int DW   = 16;
  localparam int MAXS = 4;
  localparam int TMO  = 64;

  logic       clock = 1'b0;
  logic       reset;
  arb_state_t dbg_state;
  logic [3:0] dbg_streak;

  lc3_mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  lc3_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_DATA_STREAK(MAXS), .TIMEOUT(TMO)) dut (
    .clock      (clock),
    .reset      (reset),
    .bus        (bus),
    .dbg_state  (dbg_state),
    .dbg_streak (dbg_streak)
  );

  // ---------------- clock / reset ----------------
  always #5 clock = ~clock;

  // ---------------- shared bench state ----------------
  int n_checks = 0;
  int n_pass   = 0;
  logic [DW-1:0] exp_i_q[$];
  logic [DW-1:0] exp_d_q[$];
  bit            grant_log[$];
  int            exp_err = 0;
  int            n_complete = 0;
  logic [DW-1:0] ref_mem [logic [AW-1:0]];
  logic [DW-1:0] dev_mem [logic [AW-1:0]];
  logic [DW-1:0] d_dout_model = '0;
  int            last_fetch_cycles, last_data_cycles;
  int            fixed_lat = -1;
  bit            mem_silent = 1'b0;
  bit            inject_ack = 1'b0;
  int            idx, snap_complete;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    $display("FAIL %s: event did not occur as required", name);
  endtask

  function automatic logic [DW-1:0] init_word(input logic [AW-1:0] a);
    return a ^ 16'h5A3C;
  endfunction

  function automatic logic [DW-1:0] ref_rd(input logic [AW-1:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : init_word(a);
  endfunction

  // ---------------- driver tasks ----------------
  task automatic do_fetch(input logic [AW-1:0] a, input bit tmo);
    int n = 0;
    bus.instrmem_rd = 1'b1;
    bus.pc          = a;
    exp_i_q.push_back(tmo ? '0 : ref_rd(a));
    if (tmo) exp_err++;
    do begin @(negedge clock); n++; end while (!bus.complete_instr && n < 200);
    if (!bus.complete_instr) fail_now("fetch_complete_wait");
    bus.instrmem_rd   = 1'b0;
    last_fetch_cycles = n;
  endtask

  task automatic do_data(input bit rd, input logic [AW-1:0] a, input logic [DW-1:0] din);
    int n = 0;
    bus.data_req  = 1'b1;
    bus.data_rd   = rd;
    bus.data_addr = a;
    bus.data_din  = din;
    if (rd) begin
      d_dout_model = ref_rd(a);
    end else begin
      ref_mem[a] = din;
    end
    exp_d_q.push_back(d_dout_model);
    do begin @(negedge clock); n++; end while (!bus.complete_data && n < 200);
    if (!bus.complete_data) fail_now("data_complete_wait");
    bus.data_req     = 1'b0;
    last_data_cycles = n;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_mem_req"},        bus.mem_req, 0);
    check({tag, "_mem_we"},         bus.mem_we, 0);
    check({tag, "_mem_addr"},       bus.mem_addr, 0);
    check({tag, "_mem_wdata"},      bus.mem_wdata, 0);
    check({tag, "_instr_dout"},     bus.instr_dout, 0);
    check({tag, "_data_dout"},      bus.data_dout, 0);
    check({tag, "_complete_instr"}, bus.complete_instr, 0);
    check({tag, "_complete_data"},  bus.complete_data, 0);
    check({tag, "_mem_err"},        bus.mem_err, 0);
    check({tag, "_state"},          dbg_state, IDLE);
    check({tag, "_streak"},         dbg_streak, 0);
  endtask

  // ---------------- memory agent ----------------
  initial begin
    int  wait_left;
    bit  in_acc;
    wait_left = 0;
    in_acc = 1'b0;
    bus.mem_ack   = 1'b0;
    bus.mem_rdata = '0;
    forever begin
      @(negedge clock);
      if (bus.mem_ack) begin
        bus.mem_ack = 1'b0;
        in_acc      = 1'b0;
      end else if (inject_ack) begin
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = 16'hDEAD;
      end else if (bus.mem_req && !mem_silent) begin
        if (!in_acc) begin
          in_acc    = 1'b1;
          wait_left = (fixed_lat >= 0) ? fixed_lat : int'($urandom_range(0, 3));
        end
        if (wait_left == 0) begin
          bus.mem_ack = 1'b1;
          if (bus.mem_we) dev_mem[bus.mem_addr] = bus.mem_wdata;
          else bus.mem_rdata = dev_mem.exists(bus.mem_addr) ? dev_mem[bus.mem_addr] : init_word(bus.mem_addr);
        end else begin
          wait_left--;
        end
      end else if (!bus.mem_req) begin
        in_acc = 1'b0;
      end
    end
  end

  // ---------------- input snapshot at the arbitration edge ----------------
  bit            s_rst = 1'b1, s_ireq, s_dreq, s_drd;
  logic [AW-1:0] s_pc, s_daddr;
  logic [DW-1:0] s_din;
  always @(posedge clock) begin
    s_rst   = reset;
    s_ireq  = bus.instrmem_rd;
    s_dreq  = bus.data_req;
    s_drd   = bus.data_rd;
    s_pc    = bus.pc;
    s_daddr = bus.data_addr;
    s_din   = bus.data_din;
  end

  // ---------------- monitor / scoreboard ----------------
  initial begin
    bit       mon_in_acc;
    bit       exp_data;
    int       req_cycles;
    int       fetch_waits;
    mem_cmd_t cur;
    mon_in_acc  = 1'b0;
    req_cycles  = 0;
    fetch_waits = 0;
    cur         = '0;
    forever begin
      @(negedge clock);
      if (s_rst) begin
        fetch_waits = 0;
        mon_in_acc  = 1'b0;
      end else begin
        if (bus.complete_instr || bus.complete_data) begin
          n_complete++;
          check("complete_exclusive", bus.complete_instr & bus.complete_data, 0);
        end
        if (bus.complete_instr) begin
          if (exp_i_q.size() == 0) fail_now("unexpected_complete_instr");
          else check("instr_dout", bus.instr_dout, exp_i_q.pop_front());
        end
        if (bus.complete_data) begin
          if (exp_d_q.size() == 0) fail_now("unexpected_complete_data");
          else check("data_dout", bus.data_dout, exp_d_q.pop_front());
        end
        if (bus.mem_err) begin
          if (exp_err == 0) begin
            fail_now("unexpected_mem_err");
          end else begin
            exp_err--;
            check("err_with_complete_instr", bus.complete_instr, 1);
            check("timeout_req_cycles", req_cycles, TMO);
          end
        end
        if (bus.mem_req) begin
          if (!mon_in_acc) begin
            mon_in_acc = 1'b1;
            req_cycles = 1;
            cur        = '{we: bus.mem_we, addr: bus.mem_addr, wdata: bus.mem_wdata};
            // Data wins unless a fetch has already waited out MAXS data grants.
            exp_data = s_dreq && (!s_ireq || fetch_waits < MAXS);
            grant_log.push_back(exp_data);
            if (exp_data) begin
              check("grant_data_addr",  bus.mem_addr, s_daddr);
              check("grant_data_we",    bus.mem_we, !s_drd);
              check("grant_data_wdata", bus.mem_wdata, s_din);
              fetch_waits = s_ireq ? ((fetch_waits < MAXS) ? fetch_waits + 1 : MAXS) : 0;
            end else if (s_ireq) begin
              check("grant_inst_addr", bus.mem_addr, s_pc);
              check("grant_inst_we",   bus.mem_we, 0);
              fetch_waits = 0;
            end else begin
              fail_now("grant_without_request");
            end
          end else begin
            req_cycles++;
            check("mem_cmd_stable", {bus.mem_we, bus.mem_addr, bus.mem_wdata}, cur);
          end
        end else begin
          mon_in_acc = 1'b0;
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    reset           = 1'b1;
    bus.instrmem_rd = 1'b0;
    bus.pc          = '0;
    bus.data_rd     = 1'b0;
    bus.data_req    = 1'b0;
    bus.data_addr   = '0;
    bus.data_din    = '0;
    ref_mem[16'h3000] = 16'h1220;
    dev_mem[16'h3000] = 16'h1220;

    repeat (3) @(negedge clock);
    check_all_zero("reset");
    reset = 1'b0;
    @(negedge clock);

    // fetch only, ack one cycle after mem_req
    fixed_lat = 1;
    do_fetch(16'h3000, 1'b0);
    check("t1_fetch_latency", last_fetch_cycles, 3);

    // simultaneous requests: data first, then fetch
    fixed_lat = -1;
    grant_log.delete();
    fork
      do_fetch(16'h3001, 1'b0);
      do_data(1'b1, 16'h4000, '0);
    join
    check("t2_grant_count", grant_log.size(), 2);
    if (grant_log.size() == 2) begin
      check("t2_first_is_data",  grant_log[0], 1);
      check("t2_second_is_inst", grant_log[1], 0);
    end

    // fetch held under back-to-back data writes
    grant_log.delete();
    fork
      do_fetch(16'h3002, 1'b0);
      begin
        for (int i = 0; i < 6; i++) do_data(1'b0, 16'h4100 + 16'(i), 16'($urandom));
      end
    join
    idx = -1;
    for (int i = 0; i < grant_log.size(); i++) if (!grant_log[i] && idx < 0) idx = i;
    check("t3_grant_count", grant_log.size(), 7);
    check("t3_fetch_after_max_streak", idx, MAXS);
    check("t3_streak_cleared", dbg_streak, 0);

    // write acked in the first mem_req cycle
    fixed_lat = 0;
    do_data(1'b0, 16'h5000, 16'hBEEF);
    check("t4_write_latency", last_data_cycles, 2);

    // fetch timeout
    mem_silent = 1'b1;
    do_fetch(16'h3010, 1'b1);
    check("t5_abort_latency", last_fetch_cycles, TMO + 1);
    check("t5_state_idle", dbg_state, IDLE);
    check("t5_err_seen", exp_err, 0);
    mem_silent = 1'b0;

    // reset mid-wait in DATA_BUSY, then a late ack
    mem_silent    = 1'b1;
    bus.data_req  = 1'b1;
    bus.data_rd   = 1'b1;
    bus.data_addr = 16'h4001;
    repeat (5) @(negedge clock);
    check("t6_in_data_busy", dbg_state, DATA_BUSY);
    reset = 1'b1;
    @(negedge clock);
    check_all_zero("t6_reset");
    reset        = 1'b0;
    bus.data_req = 1'b0;
    mem_silent   = 1'b0;
    d_dout_model = '0;
    snap_complete = n_complete;
    @(posedge clock);
    inject_ack = 1'b1;
    @(posedge clock);
    inject_ack = 1'b0;
    repeat (4) @(negedge clock);
    check("t6_late_ack_ignored", n_complete - snap_complete, 0);
    check("t6_still_idle", dbg_state, IDLE);

    // random traffic on both ports
    fixed_lat = -1;
    fork
      begin
        for (int i = 0; i < 40; i++) begin
          repeat ($urandom_range(0, 3)) @(negedge clock);
          do_fetch(16'h3000 + 16'($urandom_range(0, 255)), 1'b0);
        end
      end
      begin
        for (int i = 0; i < 40; i++) begin
          repeat ($urandom_range(0, 3)) @(negedge clock);
          do_data(1'($urandom_range(0, 1)), 16'h4000 + 16'($urandom_range(0, 15)), 16'($urandom));
        end
      end
    join
    repeat (3) @(negedge clock);
    check("end_instr_queue_empty", exp_i_q.size(), 0);
    check("end_data_queue_empty", exp_d_q.size(), 0);
    check("end_err_balance", exp_err, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
